// File: rtl/pwm_spi_bank_if.sv
// Pin-level bundle for the SPI-controlled PWM bank: SPI inputs, CIPO read path, error strobe, channel outputs.
// There is no valid/ready handshake: SPI pins are sampled asynchronously and outputs are level signals.
interface pwm_spi_bank_if #(
  parameter int NUM_CH = 16
);
  logic              sclk_in;
  logic              copi_in;
  logic              ncs_in;
  logic              cipo;
  logic              cipo_oe;
  logic              frame_err;
  logic [NUM_CH-1:0] out;

  modport master (
    output sclk_in, copi_in, ncs_in,
    input  cipo, cipo_oe, frame_err, out
  );

  modport slave (
    input  sclk_in, copi_in, ncs_in,
    output cipo, cipo_oe, frame_err, out
  );
endinterface

// File: rtl/pwm_spi_bank.sv
// SPI register file (write + CIPO read-back) driving a bank of prescaled PWM channels
// whose duty values are double-buffered and swapped only at the period boundary.
module pwm_spi_bank #(
  parameter int NUM_CH      = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  pwm_spi_bank_if.slave bus
);
  localparam int LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic sclk_d, ncs_d, copi_q;
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  logic        frame_act, rd_act, frame_err_q;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg, sh_next;
  logic [7:0]  rd_sh, rd_val;
  logic [6:0]  rd_addr, wr_addr;
  logic [7:0]  wr_data;
  logic        commit;

  logic [NUM_CH-1:0] en_out, en_pwm, out_q;
  logic [15:0]       en_out_w, en_pwm_w;
  logic [7:0]        duty    [NUM_CH];
  logic [7:0]        duty_sh [NUM_CH];
  logic [7:0]        presc, pcnt, cnt;
  logic              tick, wrap;

  // nCS idles high, so its synchroniser resets to 1 to avoid a phantom frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_d    <= 1'b0;
      ncs_d     <= 1'b1;
      copi_q    <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      ncs_rise  <= 1'b0;
      ncs_fall  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.copi_in};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.ncs_in};
      sclk_d    <= sclk_sync[LAST];
      ncs_d     <= ncs_sync[LAST];
      copi_q    <= copi_sync[LAST];
      sclk_rise <= sclk_sync[LAST] & ~sclk_d;
      sclk_fall <= ~sclk_sync[LAST] & sclk_d;
      ncs_rise  <= ncs_sync[LAST] & ~ncs_d;
      ncs_fall  <= ~ncs_sync[LAST] & ncs_d;
    end
  end

  assign sh_next = {shreg[14:0], copi_q};
  assign rd_addr = sh_next[6:0];
  assign wr_addr = shreg[14:8];
  assign wr_data = shreg[7:0];
  assign commit  = ncs_rise && (bit_cnt == 5'd16) && shreg[15];

  // The falling edge right after the 8th rise does not shift: bit 7 must still be
  // on CIPO when the host samples on the 9th rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_act   <= 1'b0;
      rd_act      <= 1'b0;
      frame_err_q <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rd_sh       <= '0;
    end else begin
      frame_err_q <= ncs_rise && (bit_cnt != 5'd16);
      if (ncs_rise) begin
        frame_act <= 1'b0;
        rd_act    <= 1'b0;
      end else if (ncs_fall) begin
        frame_act <= 1'b1;
        rd_act    <= 1'b0;
        bit_cnt   <= '0;
      end else if (frame_act && sclk_rise) begin
        shreg <= sh_next;
        if (bit_cnt != 5'd16) bit_cnt <= bit_cnt + 5'd1;
        if (bit_cnt == 5'd7 && !sh_next[7]) begin
          rd_sh  <= rd_val;
          rd_act <= 1'b1;
        end
      end else if (frame_act && sclk_fall && rd_act && bit_cnt > 5'd8) begin
        rd_sh <= {rd_sh[6:0], 1'b0};
      end
    end
  end

  assign en_out_w = 16'(en_out);
  assign en_pwm_w = 16'(en_pwm);

  always_comb begin
    rd_val = '0;
    if (rd_addr == 7'h00) rd_val = en_out_w[7:0];
    if (rd_addr == 7'h01) rd_val = en_out_w[15:8];
    if (rd_addr == 7'h02) rd_val = en_pwm_w[7:0];
    if (rd_addr == 7'h03) rd_val = en_pwm_w[15:8];
    if (rd_addr == 7'h20) rd_val = presc;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == 7'(4 + i)) rd_val = duty[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_out <= '0;
      en_pwm <= '0;
      presc  <= '0;
      for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_addr == 7'(i / 8))     en_out[i] <= wr_data[3'(i % 8)];
        if (wr_addr == 7'(2 + i / 8)) en_pwm[i] <= wr_data[3'(i % 8)];
        if (wr_addr == 7'(4 + i))     duty[i]   <= wr_data;
      end
      if (wr_addr == 7'h20) presc <= wr_data;
    end
  end

  assign tick = (pcnt == presc);
  assign wrap = tick && (cnt == 8'hff);

  // A duty commit coinciding with wrap loads the old value: duty[] updates on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt  <= '0;
      cnt   <= '0;
      out_q <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
    end else begin
      if (commit && wr_addr == 7'h20) pcnt <= '0;
      else if (tick)                  pcnt <= '0;
      else                            pcnt <= pcnt + 8'd1;
      if (tick) cnt <= cnt + 8'd1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en_pwm[i] || wrap) duty_sh[i] <= duty[i];
        out_q[i] <= en_out[i] & (~en_pwm[i] | (duty_sh[i] == 8'hff) | (cnt < duty_sh[i]));
      end
    end
  end

  assign bus.cipo      = rd_act & rd_sh[7];
  assign bus.cipo_oe   = ~ncs_sync[LAST];
  assign bus.frame_err = frame_err_q;
  assign bus.out       = out_q;
endmodule

// File: tb/tb_pwm_spi_bank.sv
// Directed + randomized bench for pwm_spi_bank: SPI host driver, register-map model,
// and a run-length monitor that compares PWM high/low times with duty*(presc+1).
module tb_pwm_spi_bank;
  localparam int NUM_CH = 16;
  localparam int HALF   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pwm_spi_bank_if #(.NUM_CH(NUM_CH)) bus ();

  pwm_spi_bank #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [7:0] regs_m [128];

  function automatic logic [7:0] en_mask(input int hi_byte);
    int n;
    n = NUM_CH - 8 * hi_byte;
    if (n >= 8) return 8'hff;
    if (n <= 0) return 8'h00;
    return 8'((1 << n) - 1);
  endfunction

  function automatic bit implemented(input int a);
    return (a < 4 + NUM_CH) || (a == 32);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 128; i++) regs_m[i] = 8'h00;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    if (implemented(a)) regs_m[a] = (a < 4) ? (d & en_mask(a % 2)) : d;
  endfunction

  // ---------------- monitors ----------------
  int mon_ch = 0;
  int hi_run = 0;
  int lo_run = 0;
  int hi_q[$];
  int lo_q[$];
  int err_pulses = 0;

  always @(negedge clk) begin
    if (bus.out[mon_ch] === 1'b1) begin
      if (lo_run > 0) lo_q.push_back(lo_run);
      lo_run = 0;
      hi_run++;
    end else begin
      if (hi_run > 0) hi_q.push_back(hi_run);
      hi_run = 0;
      lo_run++;
    end
    if (bus.frame_err === 1'b1) err_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("comparison %s did not hold", tag);
    end
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [7:0] rd);
    rd = '0;
    bus.ncs_in = 1'b0;
    step(HALF);
    for (int i = 0; i < nbits; i++) begin
      bus.copi_in = w[15-i];
      step(HALF);
      if (i >= 8) rd[15-i] = bus.cipo;
      bus.sclk_in = 1'b1;
      step(HALF);
      bus.sclk_in = 1'b0;
    end
    step(HALF);
    bus.ncs_in  = 1'b1;
    bus.copi_in = 1'b0;
    step(HALF);
  endtask

  task automatic spi_write(input int a, input logic [7:0] d);
    logic [7:0] unused_rd;
    spi_frame({1'b1, 7'(a), d}, 16, unused_rd);
    model_write(a, d);
  endtask

  task automatic spi_read(input int a, output logic [7:0] d);
    spi_frame({1'b0, 7'(a), 8'h00}, 16, d);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      step(1);
      if (bus.out[ch] === 1'b1) hi++;
    end
  endtask

  task automatic wait_rise(input int ch, input int budget, input string tag);
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = bus.out[ch];
    for (int k = 0; k < budget && !found; k++) begin
      step(1);
      if (!prev && bus.out[ch] === 1'b1) found = 1'b1;
      prev = bus.out[ch];
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_runs(input int n, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      step(1);
      if (hi_q.size() >= n && lo_q.size() >= n) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd;
    int hi, p, ch, d, a, err_base, period;
    logic [7:0] ebyte;

    bus.sclk_in = 1'b0;
    bus.copi_in = 1'b0;
    bus.ncs_in  = 1'b1;
    model_reset();
    step(3);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_cipo", 32'(bus.cipo), 32'd0);
    check("rst_cipo_oe", 32'(bus.cipo_oe), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    step(5);

    // enable without PWM
    spi_write(8'h00, 8'h01);
    spi_write(8'h02, 8'h00);
    step(10);
    count_high(0, 300, hi);
    check("en_only_out0", 32'(hi), 32'd300);
    check("en_only_others", 32'(bus.out >> 1), 32'd0);

    // PWM, presc = 0
    mon_ch = 0;
    spi_write(8'h04, 8'h80);
    spi_write(8'h02, 8'h01);
    step(300);
    wait_rise(0, 600, "p0_rise");
    hi_q.delete(); lo_q.delete();
    wait_runs(2, 800, "p0_runs");
    check("p0_hi0", 32'(hi_q[0]), 32'd128);
    check("p0_lo0", 32'(lo_q[0]), 32'd128);
    check("p0_hi1", 32'(hi_q[1]), 32'd128);
    spi_write(8'h04, 8'hFF);
    step(300);
    count_high(0, 512, hi);
    check("duty_ff", 32'(hi), 32'd512);
    spi_write(8'h04, 8'h00);
    step(300);
    count_high(0, 512, hi);
    check("duty_00", 32'(hi), 32'd0);

    // prescaler on channel 1
    spi_write(8'h20, 8'h03);
    spi_write(8'h05, 8'h40);
    spi_write(8'h00, 8'h03);
    spi_write(8'h02, 8'h03);
    mon_ch = 1;
    step(1100);
    wait_rise(1, 2200, "presc_rise");
    hi_q.delete(); lo_q.delete();
    wait_runs(1, 2200, "presc_runs");
    check("presc_hi", 32'(hi_q[0]), 32'd256);
    check("presc_lo", 32'(lo_q[0]), 32'd768);

    // shadow update mid-period on channel 0 (presc = 3, period 1024)
    mon_ch = 0;
    spi_write(8'h04, 8'h80);
    step(1100);
    wait_rise(0, 2200, "shadow_rise");
    hi_q.delete(); lo_q.delete();
    step(100);
    spi_write(8'h04, 8'h20);
    wait_runs(2, 3500, "shadow_runs");
    check("shadow_cur_hi", 32'(hi_q[0]), 32'd512);
    check("shadow_cur_lo", 32'(lo_q[0]), 32'd512);
    check("shadow_next_hi", 32'(hi_q[1]), 32'd128);

    // read-back
    spi_write(8'h04, 8'hA5);
    spi_read(8'h04, rd);
    check("rd_duty0", 32'(rd), 32'hA5);
    spi_read(8'h7F, rd);
    check("rd_7f", 32'(rd), 32'h00);
    spi_write(8'h7E, 8'h55);
    spi_read(8'h04, rd);
    check("rd_after_unimpl", 32'(rd), 32'hA5);
    spi_read(8'h7E, rd);
    check("rd_unimpl", 32'(rd), 32'h00);

    // short frame
    err_base = err_pulses;
    spi_frame({1'b1, 7'h04, 8'h33}, 12, rd);
    step(10);
    check("err_pulse", 32'(err_pulses), 32'(err_base + 1));
    spi_read(8'h04, rd);
    check("err_no_write", 32'(rd), 32'hA5);
    check("err_no_extra", 32'(err_pulses), 32'(err_base + 1));

    // randomized register writes / reads against the model
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 3);
        1: a = $urandom_range(4, 4 + NUM_CH - 1);
        2: a = 32;
        default: a = $urandom_range(0, 127);
      endcase
      spi_write(a, 8'($urandom_range(0, 255)));
      spi_read(a, rd);
      check($sformatf("rnd_rd_wr_%0h", a), 32'(rd), 32'(regs_m[a]));
      a = $urandom_range(0, 127);
      spi_read(a, rd);
      check($sformatf("rnd_rd_%0h", a), 32'(rd), 32'(regs_m[a]));
    end

    // randomized PWM timing
    for (int n = 0; n < 4; n++) begin
      p  = $urandom_range(0, 2);
      ch = $urandom_range(0, NUM_CH - 1);
      d  = $urandom_range(1, 254);
      period = 256 * (p + 1);
      spi_write(4 + ch, 8'(d));
      spi_write(32, 8'(p));
      ebyte = (ch < 8) ? 8'(1 << ch) : 8'h00;
      spi_write(0, ebyte);
      spi_write(2, ebyte);
      ebyte = (ch >= 8) ? 8'(1 << (ch - 8)) : 8'h00;
      spi_write(1, ebyte);
      spi_write(3, ebyte);
      mon_ch = ch;
      step(period + 20);
      wait_rise(ch, 2 * period + 50, $sformatf("rnd_rise_%0d", n));
      hi_q.delete(); lo_q.delete();
      wait_runs(1, 2 * period + 50, $sformatf("rnd_runs_%0d", n));
      check($sformatf("rnd_hi_ch%0d_d%0d_p%0d", ch, d, p), 32'(hi_q[0]), 32'(d * (p + 1)));
      check($sformatf("rnd_lo_ch%0d_d%0d_p%0d", ch, d, p), 32'(lo_q[0]), 32'((256 - d) * (p + 1)));
    end

    // reset in the middle of a frame
    spi_write(2, 8'h00);
    spi_write(3, 8'h00);
    step(10);
    check("pre_rst_out", 32'(bus.out), 32'(1 << ch));
    bus.ncs_in = 1'b0;
    step(HALF);
    for (int i = 0; i < 5; i++) begin
      bus.copi_in = 1'($urandom_range(0, 1));
      step(HALF);
      bus.sclk_in = 1'b1;
      step(HALF);
      bus.sclk_in = 1'b0;
    end
    check("pre_rst_cipo_oe", 32'(bus.cipo_oe), 32'd1);
    err_base = err_pulses;
    rst = 1'b1;
    #1;
    check("midrst_out", 32'(bus.out), 32'd0);
    check("midrst_cipo", 32'(bus.cipo), 32'd0);
    check("midrst_cipo_oe", 32'(bus.cipo_oe), 32'd0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    bus.ncs_in  = 1'b1;
    bus.copi_in = 1'b0;
    step(3);
    rst = 1'b0;
    model_reset();
    step(10);
    check("post_rst_out", 32'(bus.out), 32'd0);
    spi_read(8'h00, rd);
    check("post_rst_en_out", 32'(rd), 32'(regs_m[0]));
    spi_write(8'h05, 8'h3C);
    spi_read(8'h05, rd);
    check("post_rst_write", 32'(rd), 32'h3C);
    check("post_rst_no_err", 32'(err_pulses), 32'(err_base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
